// File: rtl/iob_fifo_pkg.sv
// Shared helpers for the asymmetric-width FIFO family: width arithmetic,
// ratio derivation and an elaboration-time legality check.
package iob_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int min_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Narrow-unit count of one write word.
    function automatic int w_ratio(input int w_data_w, input int r_data_w);
        return w_data_w / min_w(w_data_w, r_data_w);
    endfunction

    // Narrow-unit count of one read word.
    function automatic int r_ratio(input int w_data_w, input int r_data_w);
        return r_data_w / min_w(w_data_w, r_data_w);
    endfunction

    // Widths must differ by an exact power of two.
    function automatic bit ratio_ok(input int w_data_w, input int r_data_w);
        int lo;
        int hi;
        lo = min_w(w_data_w, r_data_w);
        hi = max_w(w_data_w, r_data_w);
        if (lo <= 0) begin
            return 1'b0;
        end
        return ((hi % lo) == 0) && is_pow2(hi / lo);
    endfunction

endpackage

// Used as a generate item inside a module body; stops elaboration when the
// width ratio is not a power of two or the address space cannot hold one
// wide word.
`define IOB_FIFO_PARAM_CHECK(WW, RW, AW) \
    if (!iob_fifo_pkg::ratio_ok((WW), (RW)) || \
        ((AW) < iob_fifo_pkg::clog2(iob_fifo_pkg::max_w((WW), (RW)) / \
                                    iob_fifo_pkg::min_w((WW), (RW))))) begin : g_param_check \
        $error("iob_fifo: illegal width ratio or ADDR_W too small"); \
    end

// File: rtl/iob_sync_assim_fifo_ctrl.sv
// Single-clock controller for a FIFO built on an asymmetric two-port RAM.
// Occupancy is kept in narrow (MIN_W) units so push and pop sides can move
// different amounts per transfer; the RAM provides the byte lane mapping.
module iob_sync_assim_fifo_ctrl
    import iob_fifo_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4,
    parameter int W_ADDR_W = ADDR_W - clog2(w_ratio(W_DATA_W, R_DATA_W)),
    parameter int R_ADDR_W = ADDR_W - clog2(r_ratio(W_DATA_W, R_DATA_W))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                mem_w_en,
    output logic [W_ADDR_W-1:0] mem_w_addr,
    output logic [W_DATA_W-1:0] mem_w_data,
    output logic                mem_r_en,
    output logic [R_ADDR_W-1:0] mem_r_addr,
    input  logic [R_DATA_W-1:0] mem_r_data
);

    `IOB_FIFO_PARAM_CHECK(W_DATA_W, R_DATA_W, ADDR_W)

    localparam int W_RATIO = w_ratio(W_DATA_W, R_DATA_W);
    localparam int R_RATIO = r_ratio(W_DATA_W, R_DATA_W);
    localparam int DEPTH   = 1 << ADDR_W;

    localparam logic [ADDR_W:0] W_STEP   = (ADDR_W + 1)'(W_RATIO);
    localparam logic [ADDR_W:0] R_STEP   = (ADDR_W + 1)'(R_RATIO);
    localparam logic [ADDR_W:0] FULL_THR = (ADDR_W + 1)'(DEPTH - W_RATIO);

    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]     level_nxt;
    logic                w_ok;
    logic                r_ok;

    // Flags decode straight from the registered level so they can never lag it.
    assign w_full  = (level > FULL_THR);
    assign r_empty = (level < R_STEP);

    // Acceptance uses pre-edge flags only; reset holds both RAM enables low.
    assign w_ok = w_en & ~w_full & ~rst;
    assign r_ok = r_en & ~r_empty & ~rst;

    assign mem_w_en   = w_ok;
    assign mem_w_addr = w_ptr;
    assign mem_w_data = w_data;
    assign mem_r_en   = r_ok;
    assign mem_r_addr = r_ptr;

    // RAM output is already registered, so read data is a pass-through.
    assign r_data = mem_r_data;

    // Occupancy change for this cycle in narrow units.
    always_comb begin
        level_nxt = level;
        if (w_ok) begin
            level_nxt = level_nxt + W_STEP;
        end
        if (r_ok) begin
            level_nxt = level_nxt - R_STEP;
        end
    end

    // Write pointer advances one wide/narrow write word per accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr <= '0;
        end else if (w_ok) begin
            w_ptr <= w_ptr + W_ADDR_W'(1);
        end
    end

    // Read pointer advances one read word per accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_ok) begin
            r_ptr <= r_ptr + R_ADDR_W'(1);
        end
    end

    // Occupancy register and read-valid tracking the RAM's one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= '0;
            r_valid <= 1'b0;
        end else begin
            level   <= level_nxt;
            r_valid <= r_ok;
        end
    end

endmodule
